// File: rtl/wb_pkg.sv
// Shared codes and default widths for the write-back stage and load extension.
package wb_pkg;

   localparam int unsigned DW_DEF = 32;
   localparam int unsigned AW_DEF = 5;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      WSEL_ALU  = 2'd0,
      WSEL_LOAD = 2'd1,
      WSEL_LINK = 2'd2,
      WSEL_HILO = 2'd3
   } wsel_e;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } ld_type_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: picks byte/half from a raw memory word and sign/zero extends it.
module load_ext
   import wb_pkg::*;
(
   input  logic [DW_DEF-1:0] word_i,
   input  logic [2:0]        ld_type_i,
   input  logic [1:0]        byte_off_i,
   output logic [DW_DEF-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
      // Halfword alignment comes from off[1] alone; off[0] is ignored.
      half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
      data_o   = word_i;
      case (ld_type_e'(ld_type_i))
         LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data_o = {24'h000000, byte_sel};
         LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data_o = {16'h0000, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates pipeline vs multicycle unit writes onto the register file port.
// Optional macro WB_FWD_EN adds registered and same-cycle forwarding outputs.
module wb_stage
   import wb_pkg::*;
#(
   parameter int unsigned DW           = DW_DEF,
   parameter int unsigned AW           = AW_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_wen,
   input  logic [AW-1:0] in_waddr,
   input  logic [1:0]    in_wsel,
   input  logic [DW-1:0] in_alu,
   input  logic [DW-1:0] in_mem,
   input  logic [DW-1:0] in_link,
   input  logic [DW-1:0] in_hilo,
   input  logic [2:0]    in_ld_type,
   input  logic [1:0]    in_byte_off,
   input  logic          md_req,
   input  logic [AW-1:0] md_waddr,
   input  logic [DW-1:0] md_wdata,
   output logic          md_ack,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata
`ifdef WB_FWD_EN
   ,
   output logic          fwd_valid,
   output logic [AW-1:0] fwd_addr,
   output logic [DW-1:0] fwd_data,
   output logic          nxt_valid,
   output logic [AW-1:0] nxt_addr,
   output logic [DW-1:0] nxt_data
`endif
);

   logic             rf_we_q, rf_we_d;
   logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
   logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic          starve_force;
   logic          pipe_wr;
   logic          md_grant;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] pipe_data;

   load_ext u_load_ext (
      .word_i     (in_mem),
      .ld_type_i  (in_ld_type),
      .byte_off_i (in_byte_off),
      .data_o     (ld_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         cnt_q      <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         cnt_q      <= cnt_d;
      end
   end

   // Grant, data select and starvation counter update.
   always_comb begin
      starve_force = md_req & (cnt_q == CNT_W'(STARVE_LIMIT));
      pipe_wr      = in_valid & ~starve_force & in_wen & (in_waddr != '0);
      md_grant     = md_req & (starve_force | ~pipe_wr);

      case (wsel_e'(in_wsel))
         WSEL_LOAD: pipe_data = ld_data;
         WSEL_LINK: pipe_data = in_link;
         WSEL_HILO: pipe_data = in_hilo;
         default:   pipe_data = in_alu;
      endcase

      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (md_grant) begin
         // An md write to r0 is still acked, but never reaches the regfile.
         rf_we_d    = (md_waddr != '0);
         rf_waddr_d = md_waddr;
         rf_wdata_d = md_wdata;
      end else if (pipe_wr) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = in_waddr;
         rf_wdata_d = pipe_data;
      end

      cnt_d = cnt_q;
      if (md_grant || !md_req) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign in_ready = ~starve_force;
   assign md_ack   = md_grant;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

`ifdef WB_FWD_EN
   assign fwd_valid = rf_we_q;
   assign fwd_addr  = rf_waddr_q;
   assign fwd_data  = rf_wdata_q;
   assign nxt_valid = rf_we_d;
   assign nxt_addr  = rf_waddr_d;
   assign nxt_data  = rf_wdata_d;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus a random run against a behavioural model.
module tb_wb_stage;

   localparam int unsigned LIMIT = 4;

   logic        clk, reset;
   logic        in_valid, in_ready, in_wen;
   logic [4:0]  in_waddr, md_waddr, rf_waddr;
   logic [1:0]  in_wsel, in_byte_off;
   logic [2:0]  in_ld_type;
   logic [31:0] in_alu, in_mem, in_link, in_hilo, md_wdata, rf_wdata;
   logic        md_req, md_ack, rf_we;
`ifdef WB_FWD_EN
   logic        fwd_valid, nxt_valid;
   logic [4:0]  fwd_addr, nxt_addr;
   logic [31:0] fwd_data, nxt_data;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Model state: expected registered write and denial count
   int          m_cnt;
   logic        e_we;
   logic [4:0]  e_addr;
   logic [31:0] e_data;
   bit          last_ack, last_fire;

   wb_stage #(.DW(32), .AW(5), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_waddr(in_waddr),
      .in_wsel(in_wsel), .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
      .in_hilo(in_hilo), .in_ld_type(in_ld_type), .in_byte_off(in_byte_off),
      .md_req(md_req), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_ack(md_ack),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
      , .nxt_valid(nxt_valid), .nxt_addr(nxt_addr), .nxt_data(nxt_data)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [2:0] ldt,
                                            input logic [1:0] off);
      logic [31:0] b, h;
      b = (mem >> (8 * off)) & 32'hFF;
      h = (mem >> (off[1] ? 16 : 0)) & 32'hFFFF;
      case (ldt)
         3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'd2:    return b;
         3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4:    return h;
         default: return mem;
      endcase
   endfunction

   function automatic logic [31:0] ref_data();
      case (in_wsel)
         2'd1:    return ref_load(in_mem, in_ld_type, in_byte_off);
         2'd2:    return in_link;
         2'd3:    return in_hilo;
         default: return in_alu;
      endcase
   endfunction

   // Called at posedge+1 with inputs set; checks comb outputs, then the registered result.
   task automatic cycle();
      bit          f, pw, mg;
      logic        n_we;
      logic [4:0]  n_addr;
      logic [31:0] n_data;
      int          n_cnt;
      #2;
      f  = md_req && (m_cnt == LIMIT);
      pw = in_valid && !f && in_wen && (in_waddr != 0);
      mg = md_req && (f || !pw);
      check("in_ready", in_ready, !f);
      check("md_ack", md_ack, mg);
      n_we = 1'b0; n_addr = e_addr; n_data = e_data;
      if (mg) begin
         n_we = (md_waddr != 0); n_addr = md_waddr; n_data = md_wdata;
      end else if (pw) begin
         n_we = 1'b1; n_addr = in_waddr; n_data = ref_data();
      end
      n_cnt = (mg || !md_req) ? 0 : ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1);
`ifdef WB_FWD_EN
      check("nxt_valid", nxt_valid, n_we);
      check("nxt_addr", nxt_addr, n_addr);
      check("nxt_data", nxt_data, n_data);
`endif
      last_ack  = mg;
      last_fire = in_valid && !f;
      @(posedge clk);
      #1;
      e_we = n_we; e_addr = n_addr; e_data = n_data; m_cnt = n_cnt;
      check("rf_we", rf_we, e_we);
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
`ifdef WB_FWD_EN
      check("fwd_valid", fwd_valid, e_we);
      check("fwd_addr", fwd_addr, e_addr);
      check("fwd_data", fwd_data, e_data);
`endif
   endtask

   task automatic new_pipe_wr();
      in_valid = 1'b1; in_wen = 1'b1;
      in_waddr = 5'($urandom_range(10, 31));
      in_wsel  = 2'd0;
      in_alu   = $urandom;
   endtask

   // md held against a continuous pipeline stream: ack must come on the 5th cycle.
   task automatic arb_run(input string tag);
      int n;
      logic [4:0] p_addr;
      n = -1;
      md_req = 1'b1; md_waddr = 5'd9; md_wdata = $urandom;
      new_pipe_wr();
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (last_ack) begin
            n = i;
            break;
         end
         if (last_fire) new_pipe_wr();
      end
      check(tag, n, 4);
      check({tag, "_md_addr"}, rf_waddr, 5'd9);
      p_addr = in_waddr;
      md_req = 1'b0;
      cycle();
      check({tag, "_pipe_after"}, rf_waddr, p_addr);
      in_valid = 1'b0;
   endtask

   logic [2:0]  ld_tbl_t [8] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0, 3'd6, 3'd3};
   logic [1:0]  ld_tbl_o [8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1};
   logic [31:0] ld_tbl_w [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_807F,
                                 32'h0000_FF80, 32'h807F_FF80, 32'h807F_FF80, 32'hFFFF_FF80};

   initial begin
      reset = 1'b0;
      in_valid = 0; in_wen = 0; in_waddr = 0; in_wsel = 0; in_alu = 0; in_mem = 0;
      in_link = 0; in_hilo = 0; in_ld_type = 0; in_byte_off = 0;
      md_req = 0; md_waddr = 0; md_wdata = 0;
      m_cnt = 0; e_we = 0; e_addr = 0; e_data = 0; last_ack = 0; last_fire = 0;
      #3;
      check("rst_we", rf_we, 1'b0);
      check("rst_waddr", rf_waddr, 5'd0);
      check("rst_wdata", rf_wdata, 32'd0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_md_ack", md_ack, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Load extension sweep
      in_mem = 32'h807F_FF80;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_wen = 1; in_waddr = 5'(i + 1); in_wsel = 2'd1;
         in_ld_type = ld_tbl_t[i]; in_byte_off = ld_tbl_o[i];
         cycle();
         check("ld_tbl_data", rf_wdata, ld_tbl_w[i]);
      end

      // r0 suppression from both sources
      in_waddr = 5'd0; in_wsel = 2'd0; in_alu = 32'h1234_5678;
      cycle();
      check("r0_pipe_we", rf_we, 1'b0);
      in_valid = 0; md_req = 1; md_waddr = 5'd0; md_wdata = 32'hDEAD_BEEF;
      cycle();
      check("r0_md_ack", last_ack, 1'b1);
      check("r0_md_we", rf_we, 1'b0);
      md_req = 0;

      // Idle slot: pipeline fires without a write, md takes the port
      in_valid = 1; in_wen = 0; in_waddr = 5'd3;
      md_req = 1; md_waddr = 5'd7; md_wdata = 32'hCAFE_0007;
      cycle();
      check("idle_md_we", rf_we, 1'b1);
      md_req = 0; in_valid = 0;

      arb_run("arb_force_cycle");

      // Async reset with rf_we=1 and three denials accumulated
      md_req = 1; md_waddr = 5'd11; md_wdata = $urandom;
      new_pipe_wr();
      for (int i = 0; i < 3; i++) begin
         cycle();
         new_pipe_wr();
      end
      check("pre_rst_we", rf_we, 1'b1);
      #3 reset = 1'b0;
      #1;
      check("arst_we", rf_we, 1'b0);
      check("arst_waddr", rf_waddr, 5'd0);
      check("arst_wdata", rf_wdata, 32'd0);
      e_we = 0; e_addr = 0; e_data = 0; m_cnt = 0;
      md_req = 0; in_valid = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      arb_run("rst_force_cycle");

      // Random traffic; md obeys hold-until-ack
      last_ack = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!md_req || last_ack) begin
            md_req   = ($urandom_range(0, 2) != 0);
            md_waddr = 5'($urandom_range(0, 31));
            md_wdata = $urandom;
         end
         in_valid    = ($urandom_range(0, 3) != 0);
         in_wen      = ($urandom_range(0, 4) != 0);
         in_waddr    = 5'($urandom_range(0, 31));
         in_wsel     = 2'($urandom_range(0, 3));
         in_alu      = $urandom;
         in_mem      = $urandom;
         in_link     = $urandom;
         in_hilo     = $urandom;
         in_ld_type  = 3'($urandom_range(0, 7));
         in_byte_off = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage sitting directly upstream of the 32x32 register file write port (we/waddr/wdata, written on falling clk edge).
- Merges two write sources into the single write port:
  - the in-order pipeline result (ALU, load, link, HI/LO);
  - completions from the multicycle multiply/divide unit.
- Performs load-data extraction and sign/zero extension.
- Registers the winning write for exactly one cycle.
- Arbitrates with a starvation counter so the multicycle unit cannot be locked out.

Parameters:
- DW, 32, data width.
- AW, 5, register address width.
- STARVE_LIMIT, 4, consecutive denied md_req cycles before md forces priority (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  pipeline result valid.
- in_ready  out  1  stage can accept pipeline result this cycle.
- in_wen  in  1  instruction writes a register.
- in_waddr  in  AW  destination register.
- in_wsel  in  2  source select: 0 ALU, 1 load, 2 link, 3 HI/LO.
- in_alu  in  DW  ALU result.
- in_mem  in  DW  raw data-memory word.
- in_link  in  DW  link address (already computed upstream).
- in_hilo  in  DW  HI or LO value.
- in_ld_type  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw.
- in_byte_off  in  2  address bits [1:0] of the load.
- md_req  in  1  multicycle unit requests a register write.
- md_waddr  in  AW  its destination.
- md_wdata  in  DW  its data.
- md_ack  out  1  one-cycle pulse: md write taken this cycle.
- rf_we  out  1  to regfile we.
- rf_waddr  out  AW  to regfile waddr.
- rf_wdata  out  DW  to regfile wdata.

Behaviour:
- Reset (reset==0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, starvation counter=0. md_ack and in_ready are combinational and follow the rules below with counter=0.
- Pipeline fire: pipe_fire = in_valid & in_ready.
- Pipeline write: pipe_wr = pipe_fire & in_wen & (in_waddr!=0).
- Starvation: force = md_req & (cnt == STARVE_LIMIT).
- in_ready = ~force.
- Grant (combinational, same cycle):
  - force=1: md granted; the pipeline stalls that cycle.
  - else if pipe_wr=1: pipeline granted; md waits.
  - else if md_req=1: md granted. This includes cycles where the pipeline fires with no write, or in_valid=0.
- md_ack = md granted. The md unit must hold md_req/md_waddr/md_wdata stable until md_ack. The cycle after md_ack it may drop md_req or present the next request.
- Counter update per rising edge:
  - clear on md_ack or on ~md_req;
  - else increment, saturating at STARVE_LIMIT.
- Registered output, 1-cycle latency: on the rising edge after a grant, rf_we=1 and rf_waddr/rf_wdata take the granted values. With no grant, rf_we=0; waddr/wdata hold their previous values.
- A granted md write with md_waddr==0 is acked but produces rf_we=0.
- Writes to r0 are therefore never issued.
- Data select:
  - wsel 0 → in_alu.
  - wsel 2 → in_link.
  - wsel 3 → in_hilo.
  - wsel 1 → extended load data:
    - lb/lbu: byte in_mem[8*off+7 : 8*off], sign/zero extended.
    - lh/lhu: half selected by off[1] only (off[0] ignored), sign/zero extended.
    - lw: in_mem unmodified; off ignored.
- Simultaneous pipe_wr and md_req with cnt<STARVE_LIMIT: pipeline wins and cnt increments.
- Reset mid-request: any pending md request is dropped with no ack. The md unit re-presents it after reset (its own reset clears it).
- Back-to-back: one write per cycle maximum, sustained indefinitely.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_addr (AW), fwd_data (DW).
  - These carry the current registered write (= rf_we/rf_waddr/rf_wdata) for the EX-stage bypass mux.
  - Also adds a comb-path variant nxt_valid/nxt_addr/nxt_data showing the grant being made this cycle.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - WSEL_ALU/WSEL_LOAD/WSEL_LINK/WSEL_HILO codes;
  - LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU codes;
  - DW/AW defaults.
- One combinational sub-module, load_ext: inputs raw word, ld_type and byte_off; output the extended word. It is reusable by the data-memory side.

Test Plan:
- Load extension: in_mem=0x807F_FF80, wsel=1, sweep ld_type/byte_off → lb off0=0xFFFFFF80, lbu off0=0x00000080, lb off2=0x0000007F, lh off2=0xFFFF807F, lhu off0=0x0000FF80, lw=0x807FFF80; rf_we=1 one cycle after fire.
- r0 suppression: pipeline write waddr=0, data 0x12345678 → rf_we=0. md_req waddr=0 → md_ack=1, rf_we=0.
- Arbitration: pipe_wr every cycle plus md_req held, STARVE_LIMIT=4.
  - Expected: md denied 4 cycles, 5th cycle in_ready=0 and md_ack=1.
  - Expected: rf_waddr=md_waddr next cycle; pipeline instruction written the cycle after.
- Idle slot: in_valid=1, in_wen=0 with md_req → md_ack same cycle, in_ready stays 1, counter stays 0.
- Reset: assert reset=0 asynchronously mid-cycle while rf_we=1 and cnt=3 → rf_we/rf_waddr/rf_wdata=0 immediately. After release, a new md_req needs 4 denials before force.
- WB_FWD_EN build: fwd_* equals rf_* every cycle over a 1000-cycle random run. Non-macro build compiles without fwd ports.
